// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// the default memory timeout and the control-output bundle with its presets.
package pipe_hazard_ctrl_pkg;

  localparam int DEFAULT_MEM_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic stall_fd;
    logic stall_dx;
    logic bubble_dx;
    logic flush_fd;
    logic flush_dx;
    logic pc_en;
  } ctrl_out_t;

  // Pipeline advances freely.
  localparam ctrl_out_t CTRL_IDLE = '{stall_fd: 1'b0, stall_dx: 1'b0, bubble_dx: 1'b0,
                                      flush_fd: 1'b0, flush_dx: 1'b0, pc_en: 1'b1};
  // FD and DX frozen, PC held.
  localparam ctrl_out_t CTRL_HOLD = '{stall_fd: 1'b1, stall_dx: 1'b1, bubble_dx: 1'b0,
                                      flush_fd: 1'b0, flush_dx: 1'b0, pc_en: 1'b0};

  // Outputs when no memory wait is pending: a taken branch squashes the
  // younger instructions (which also removes any load-use dependency),
  // otherwise a load-use hazard holds FD for one cycle and injects a NOP.
  function automatic ctrl_out_t run_outputs(input logic branch, input logic load_use);
    ctrl_out_t o;
    o = CTRL_IDLE;
    if (branch) begin
      o.flush_fd = 1'b1;
      o.flush_dx = 1'b1;
    end else if (load_use) begin
      o.stall_fd  = 1'b1;
      o.bubble_dx = 1'b1;
      o.pc_en     = 1'b0;
    end
    return o;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard
// controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int RF_ADDR_W = 5,
  parameter int CNT_W     = 32
);
  logic [RF_ADDR_W-1:0] rs_addr_fd;
  logic [RF_ADDR_W-1:0] rd_addr_fd;
  logic                 uses_rs_fd;
  logic                 uses_rd_fd;
  logic [RF_ADDR_W-1:0] dest_addr_dx;
  logic                 is_load_dx;
  logic                 writes_rf_dx;
  logic                 branch_taken_x;
  logic                 mem_req_m;
  logic                 mem_ack;

  logic                 stall_fd;
  logic                 stall_dx;
  logic                 bubble_dx;
  logic                 flush_fd;
  logic                 flush_dx;
  logic                 pc_en;
  logic                 mem_timeout_err;
  logic [CNT_W-1:0]     stall_count;
  logic [CNT_W-1:0]     flush_count;
  logic [1:0]           state_o;

  modport master (
    output rs_addr_fd, rd_addr_fd, uses_rs_fd, uses_rd_fd, dest_addr_dx,
           is_load_dx, writes_rf_dx, branch_taken_x, mem_req_m, mem_ack,
    input  stall_fd, stall_dx, bubble_dx, flush_fd, flush_dx, pc_en,
           mem_timeout_err, stall_count, flush_count, state_o
  );

  modport slave (
    input  rs_addr_fd, rd_addr_fd, uses_rs_fd, uses_rd_fd, dest_addr_dx,
           is_load_dx, writes_rf_dx, branch_taken_x, mem_req_m, mem_ack,
    output stall_fd, stall_dx, bubble_dx, flush_fd, flush_dx, pc_en,
           mem_timeout_err, stall_count, flush_count, state_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count enabled events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process evaluation order.
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: resolves memory waits, taken branches and
// load-use hazards into stall/flush/bubble controls, detects memory timeouts
// and counts stall and flush cycles.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RF_ADDR_W   = 5,
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q;
  ctrl_out_t         ctl;
  logic              load_use;
  logic              mem_wait;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign load_use = bus.is_load_dx && bus.writes_rf_dx && (bus.dest_addr_dx != '0) &&
                    ((bus.uses_rs_fd && (bus.rs_addr_fd == bus.dest_addr_dx)) ||
                     (bus.uses_rd_fd && (bus.rd_addr_fd == bus.dest_addr_dx)));

  assign mem_wait = bus.mem_req_m && !bus.mem_ack;

  // Next-state and Mealy outputs; reset forces a frozen pipeline.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    wait_d  = wait_q;
    ctl     = CTRL_IDLE;
    unique case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          ctl     = CTRL_HOLD;
          state_d = ST_MEM_WAIT;
          wait_d  = '0;
        end else begin
          ctl = run_outputs(bus.branch_taken_x, load_use);
        end
      end
      ST_MEM_WAIT: begin
        if (bus.mem_ack) begin
          // Ack wins over a coinciding timeout; the pipeline resumes this cycle.
          ctl     = run_outputs(bus.branch_taken_x, load_use);
          state_d = ST_RUN;
          wait_d  = '0;
        end else begin
          // A taken branch is held by the frozen pipeline and acted on later.
          ctl = CTRL_HOLD;
          if (wait_q == WAIT_LAST) begin
            state_d = ST_ERROR;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      ST_ERROR: begin
        ctl = CTRL_HOLD;
      end
      default: begin
        ctl     = CTRL_HOLD;
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
    if (!rst_n) begin
      ctl = CTRL_HOLD;
    end
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_q || (state_d == ST_ERROR);
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctl.stall_fd || ctl.bubble_dx),
    .count (bus.stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctl.flush_fd),
    .count (bus.flush_count)
  );

  assign bus.stall_fd        = ctl.stall_fd;
  assign bus.stall_dx        = ctl.stall_dx;
  assign bus.bubble_dx       = ctl.bubble_dx;
  assign bus.flush_fd        = ctl.flush_fd;
  assign bus.flush_dx        = ctl.flush_dx;
  assign bus.pc_en           = ctl.pc_en;
  assign bus.mem_timeout_err = err_q;
  assign bus.state_o         = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl. dut0 uses default parameters,
// dut1 uses MEM_TIMEOUT=8 and CNT_W=4 for timeout and saturation scenarios.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.RF_ADDR_W(5), .CNT_W(32)) bus0 ();
  pipe_hazard_ctrl_if #(.RF_ADDR_W(5), .CNT_W(4))  bus1 ();

  pipe_hazard_ctrl #(.RF_ADDR_W(5), .MEM_TIMEOUT(255), .CNT_W(32)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  pipe_hazard_ctrl #(.RF_ADDR_W(5), .MEM_TIMEOUT(8), .CNT_W(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  // Control outputs packed as {stall_fd, stall_dx, bubble_dx, flush_fd, flush_dx, pc_en}.
  logic [5:0] ctl0, ctl1;
  assign ctl0 = {bus0.stall_fd, bus0.stall_dx, bus0.bubble_dx, bus0.flush_fd, bus0.flush_dx, bus0.pc_en};
  assign ctl1 = {bus1.stall_fd, bus1.stall_dx, bus1.bubble_dx, bus1.flush_fd, bus1.flush_dx, bus1.pc_en};

  localparam logic [5:0] C_IDLE   = 6'b000001;
  localparam logic [5:0] C_HOLD   = 6'b110000;
  localparam logic [5:0] C_BUBBLE = 6'b101000;
  localparam logic [5:0] C_FLUSH  = 6'b000111;

  task automatic clear_inputs();
    bus0.rs_addr_fd = '0; bus0.rd_addr_fd = '0; bus0.uses_rs_fd = 0; bus0.uses_rd_fd = 0;
    bus0.dest_addr_dx = '0; bus0.is_load_dx = 0; bus0.writes_rf_dx = 0;
    bus0.branch_taken_x = 0; bus0.mem_req_m = 0; bus0.mem_ack = 0;
    bus1.rs_addr_fd = '0; bus1.rd_addr_fd = '0; bus1.uses_rs_fd = 0; bus1.uses_rd_fd = 0;
    bus1.dest_addr_dx = '0; bus1.is_load_dx = 0; bus1.writes_rf_dx = 0;
    bus1.branch_taken_x = 0; bus1.mem_req_m = 0; bus1.mem_ack = 0;
  endtask

  // Advance one clock; inputs are then driven 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    #2 rst_n = 1'b0;
    #3;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    bus0.branch_taken_x = 1'b1;
    #3;
    checks++; if (ctl0 !== C_HOLD) begin failures++; $display("FAIL reset_ctl: got %b expected %b", ctl0, C_HOLD); end
    checks++; if (bus0.state_o !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", bus0.state_o); end
    checks++; if (bus0.stall_count !== 32'd0 || bus0.flush_count !== 32'd0) begin failures++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", bus0.stall_count, bus0.flush_count); end
    checks++; if (bus0.mem_timeout_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", bus0.mem_timeout_err); end
    step();
    clear_inputs();
    rst_n = 1'b1;
    #1;
    checks++; if (ctl0 !== C_IDLE) begin failures++; $display("FAIL idle_ctl: got %b expected %b", ctl0, C_IDLE); end
    step(); step();
    checks++; if (bus0.stall_count !== 32'd0 || bus0.flush_count !== 32'd0) begin failures++; $display("FAIL idle_counts: got %0d/%0d expected 0/0", bus0.stall_count, bus0.flush_count); end
  endtask

  typedef struct {
    logic       load; logic wr;
    logic [4:0] dest; logic [4:0] rs; logic [4:0] rd;
    logic       urs;  logic urd;
    logic       hazard;
  } lu_vec_t;

  task automatic test_load_use();
    lu_vec_t v [7];
    v[0] = '{1, 1, 5'd3, 5'd3, 5'd0, 1, 0, 1};  // rs match
    v[1] = '{1, 1, 5'd3, 5'd3, 5'd0, 0, 0, 0};  // rs matches but unused
    v[2] = '{1, 1, 5'd3, 5'd4, 5'd3, 1, 1, 1};  // rd match
    v[3] = '{0, 1, 5'd3, 5'd3, 5'd0, 1, 0, 0};  // not a load
    v[4] = '{1, 0, 5'd3, 5'd3, 5'd0, 1, 0, 0};  // no rf write
    v[5] = '{1, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0};  // dest is r0
    v[6] = '{1, 1, 5'd7, 5'd6, 5'd5, 1, 1, 0};  // no address match
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      bus0.is_load_dx = v[i].load; bus0.writes_rf_dx = v[i].wr; bus0.dest_addr_dx = v[i].dest;
      bus0.rs_addr_fd = v[i].rs; bus0.rd_addr_fd = v[i].rd;
      bus0.uses_rs_fd = v[i].urs; bus0.uses_rd_fd = v[i].urd;
      #1;
      checks++;
      if (ctl0 !== (v[i].hazard ? C_BUBBLE : C_IDLE)) begin
        failures++; $display("FAIL load_use_vec%0d: got %b expected %b", i, ctl0, (v[i].hazard ? C_BUBBLE : C_IDLE));
      end
      step();
      clear_inputs();
      #1;
      if (i == 0) begin
        checks++; if (bus0.stall_count !== 32'd1 || ctl0 !== C_IDLE) begin failures++; $display("FAIL load_use_single: got cnt=%0d ctl=%b expected cnt=1 ctl=%b", bus0.stall_count, ctl0, C_IDLE); end
      end
    end
    checks++; if (bus0.stall_count !== 32'd2) begin failures++; $display("FAIL load_use_count: got %0d expected 2", bus0.stall_count); end
  endtask

  task automatic test_branch_load_use();
    apply_reset();
    bus0.branch_taken_x = 1; bus0.is_load_dx = 1; bus0.writes_rf_dx = 1;
    bus0.dest_addr_dx = 5'd3; bus0.rs_addr_fd = 5'd3; bus0.uses_rs_fd = 1;
    #1;
    checks++; if (ctl0 !== C_FLUSH) begin failures++; $display("FAIL branch_ctl: got %b expected %b", ctl0, C_FLUSH); end
    step();
    clear_inputs();
    #1;
    checks++; if (bus0.flush_count !== 32'd1 || bus0.stall_count !== 32'd0) begin failures++; $display("FAIL branch_counts: got %0d/%0d expected flush=1 stall=0", bus0.flush_count, bus0.stall_count); end
  endtask

  task automatic test_mem_wait();
    apply_reset();
    bus0.mem_req_m = 1; bus0.branch_taken_x = 1;  // memory wait outranks branch
    #1;
    checks++; if (ctl0 !== C_HOLD || bus0.state_o !== 2'd0) begin failures++; $display("FAIL mem_first: got ctl=%b st=%0d expected ctl=%b st=0", ctl0, bus0.state_o, C_HOLD); end
    for (int i = 1; i < 4; i++) begin
      step();
      checks++; if (ctl0 !== C_HOLD || bus0.state_o !== 2'd1) begin failures++; $display("FAIL mem_wait%0d: got ctl=%b st=%0d expected ctl=%b st=1", i, ctl0, bus0.state_o, C_HOLD); end
    end
    step();
    bus0.mem_ack = 1;
    #1;
    checks++; if (ctl0 !== C_FLUSH || bus0.state_o !== 2'd1) begin failures++; $display("FAIL mem_ack: got ctl=%b st=%0d expected ctl=%b st=1", ctl0, bus0.state_o, C_FLUSH); end
    step();
    clear_inputs();
    #1;
    checks++; if (bus0.state_o !== 2'd0 || ctl0 !== C_IDLE) begin failures++; $display("FAIL mem_done: got ctl=%b st=%0d expected ctl=%b st=0", ctl0, bus0.state_o, C_IDLE); end
    checks++; if (bus0.stall_count !== 32'd4 || bus0.flush_count !== 32'd1) begin failures++; $display("FAIL mem_counts: got %0d/%0d expected stall=4 flush=1", bus0.stall_count, bus0.flush_count); end
  endtask

  task automatic test_timeout();
    apply_reset();
    bus1.mem_req_m = 1;
    for (int e = 1; e <= 9; e++) begin
      step();
      if (e >= 8) begin
        checks++;
        if (bus1.state_o !== ((e == 9) ? 2'd2 : 2'd1) || bus1.mem_timeout_err !== (e == 9)) begin
          failures++; $display("FAIL timeout_edge%0d: got st=%0d err=%b expected st=%0d err=%b", e, bus1.state_o, bus1.mem_timeout_err, ((e == 9) ? 2 : 1), (e == 9));
        end
      end
    end
    bus1.mem_req_m = 0; bus1.mem_ack = 1;
    step(); step(); step();
    #1;
    checks++; if (bus1.state_o !== 2'd2 || bus1.mem_timeout_err !== 1'b1 || ctl1 !== C_HOLD) begin failures++; $display("FAIL error_sticky: got st=%0d err=%b ctl=%b expected st=2 err=1 ctl=%b", bus1.state_o, bus1.mem_timeout_err, ctl1, C_HOLD); end
    checks++; if (bus1.stall_count !== 4'd12) begin failures++; $display("FAIL error_stall_count: got %0d expected 12", bus1.stall_count); end
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++; if (bus1.state_o !== 2'd0 || bus1.mem_timeout_err !== 1'b0 || bus1.stall_count !== 4'd0) begin failures++; $display("FAIL error_reset: got st=%0d err=%b cnt=%0d expected 0/0/0", bus1.state_o, bus1.mem_timeout_err, bus1.stall_count); end
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (ctl1 !== C_IDLE) begin failures++; $display("FAIL error_release: got %b expected %b", ctl1, C_IDLE); end
  endtask

  task automatic test_saturation();
    apply_reset();
    bus1.is_load_dx = 1; bus1.writes_rf_dx = 1; bus1.dest_addr_dx = 5'd9;
    bus1.rd_addr_fd = 5'd9; bus1.uses_rd_fd = 1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 14 || c == 20) begin
        checks++;
        if (bus1.stall_count !== ((c == 14) ? 4'd14 : 4'd15)) begin
          failures++; $display("FAIL sat_count_c%0d: got %0d expected %0d", c, bus1.stall_count, ((c == 14) ? 14 : 15));
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    bus0.mem_req_m = 1;
    step(); step(); step();
    checks++; if (bus0.state_o !== 2'd1) begin failures++; $display("FAIL midwait_state: got %0d expected 1", bus0.state_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus0.state_o !== 2'd0) begin failures++; $display("FAIL midwait_async: got %0d expected 0", bus0.state_o); end
    clear_inputs();
    step();
    rst_n = 1'b1;
    step();
    checks++; if (ctl0 !== C_IDLE || bus0.state_o !== 2'd0) begin failures++; $display("FAIL midwait_release: got ctl=%b st=%0d expected ctl=%b st=0", ctl0, bus0.state_o, C_IDLE); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch_load_use();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
